// File: rtl/param_shift_register.sv
// param_shift_register: WIDTH-bit universal register with clock enable, parallel
// load, logical/arithmetic shifts and rotates, a shift counter and a one-cycle
// done pulse at each completed WIDTH-bit serial word.
// Optional feature macro: PARITY_EN (registered XOR-reduction of q on the parity port).
module param_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             done,
  output logic             parity
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_LOAD  = 3'b001,
    M_SHL   = 3'b010,
    M_SHR   = 3'b011,
    M_ROL   = 3'b100,
    M_ROR   = 3'b101,
    M_ASR   = 3'b110,
    M_CLEAR = 3'b111
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mode_e            mode_s;
  logic [WIDTH-1:0] q_q,    q_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             done_q, done_d;
  logic             is_shift;

  assign mode_s = mode_e'(mode);

  // Next-state data path: operation select plus word counter and done pulse.
  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    is_shift = 1'b0;
    if (en) begin
      unique case (mode_s)
        M_HOLD:  q_d = q_q;
        M_LOAD:  begin q_d = d;  cnt_d = '0; end
        M_SHL:   begin q_d = {q_q[WIDTH-2:0], ser_in_l};     is_shift = 1'b1; end
        M_SHR:   begin q_d = {ser_in_r, q_q[WIDTH-1:1]};     is_shift = 1'b1; end
        M_ROL:   begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; is_shift = 1'b1; end
        M_ROR:   begin q_d = {q_q[0], q_q[WIDTH-1:1]};       is_shift = 1'b1; end
        M_ASR:   begin q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; is_shift = 1'b1; end
        M_CLEAR: begin q_d = '0; cnt_d = '0; end
        default: q_d = q_q;
      endcase
      if (is_shift) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
        end
      end
    end
  end

  // State registers; synchronous reset discards any partial word.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q         = q_q;
  assign shift_cnt = cnt_q;
  assign done      = done_q;

`ifdef PARITY_EN
  logic par_q;

  // Parity tracks the next q so it always matches the registered contents.
  always_ff @(posedge clock) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= ^q_d;
  end

  assign parity = par_q;
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_param_shift_register.sv
// Scoreboard bench for param_shift_register (WIDTH=8): the stimulus process
// pushes the hand-derived expected state for each cycle; a monitor pops and
// compares one cycle later.
module tb_param_shift_register;

  localparam int W  = 8;
  localparam int CW = 4;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                         ROL  = 3'b100, ROR  = 3'b101, ASR = 3'b110, CLR = 3'b111;

  logic          clock = 1'b0;
  logic          reset, en, ser_in_l, ser_in_r;
  logic [2:0]    mode;
  logic [W-1:0]  d, q;
  logic [CW-1:0] shift_cnt;
  logic          done, parity;

  typedef struct {
    int            idx;
    logic [W-1:0]  q;
    logic [CW-1:0] cnt;
    logic          done;
    logic          par;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  param_shift_register #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .ser_in_l (ser_in_l),
    .ser_in_r (ser_in_r),
    .q        (q),
    .shift_cnt(shift_cnt),
    .done     (done),
    .parity   (parity)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, expv);
    end
  endtask

  // Drive one cycle of stimulus and record the state expected after the next edge.
  task automatic step(input logic r, input logic e, input logic [2:0] m, input logic [W-1:0] dd,
                      input logic sl, input logic sr,
                      input logic [W-1:0] eq, input logic [CW-1:0] ec, input logic ed);
    exp_t x;
    @(negedge clock);
    reset = r; en = e; mode = m; d = dd; ser_in_l = sl; ser_in_r = sr;
    step_no++;
    x.idx = step_no; x.q = eq; x.cnt = ec; x.done = ed;
`ifdef PARITY_EN
    x.par = ^eq;
`else
    x.par = 1'b0;
`endif
    exp_q.push_back(x);
  endtask

  // Monitor: every cycle the DUT presents a new registered state.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("q",      x.idx, 32'(q),         32'(x.q));
        chk("cnt",    x.idx, 32'(shift_cnt), 32'(x.cnt));
        chk("done",   x.idx, 32'(done),      32'(x.done));
        chk("parity", x.idx, 32'(parity),    32'(x.par));
      end
    end
  end

  initial begin
    logic [W-1:0] ones;
    int           waited;
    ones = '1;
    reset = 1'b1; en = 1'b1; mode = LOAD; d = 8'hFF; ser_in_l = 1'b0; ser_in_r = 1'b0;

    // Reset wins over LOAD.
    step(1, 1, LOAD, 8'hFF, 0, 0, 8'h00, 0, 0);
    step(1, 1, LOAD, 8'hFF, 0, 0, 8'h00, 0, 0);

    // Rotates and arithmetic shift, then HOLD mid-word.
    step(0, 1, LOAD, 8'hA5, 0, 0, 8'hA5, 0, 0);
    step(0, 1, ROL,  8'h00, 0, 0, 8'h4B, 1, 0);
    step(0, 1, ROR,  8'h00, 0, 0, 8'hA5, 2, 0);
    step(0, 1, ASR,  8'h00, 0, 0, 8'hD2, 3, 0);
    step(0, 1, HOLD, 8'h00, 1, 1, 8'hD2, 3, 0);

    // Serial fill from the left: done only after the 8th shift.
    step(0, 1, LOAD, 8'h00, 0, 0, 8'h00, 0, 0);
    for (int i = 1; i <= 8; i++)
      step(0, 1, SHL, 8'h00, 1, 0, ones >> (8 - i), CW'(i % 8), i == 8);

    // SHR 5, disable 3 cycles (count held), SHR 3 more.
    for (int i = 1; i <= 5; i++)
      step(0, 1, SHR, 8'h00, 0, 0, ones >> i, CW'(i), 0);
    for (int i = 0; i < 3; i++)
      step(0, 0, SHR, 8'h00, 0, 0, 8'h07, 5, 0);
    for (int i = 6; i <= 8; i++)
      step(0, 1, SHR, 8'h00, 0, 0, ones >> i, CW'(i % 8), i == 8);

    // Partial word then reset: no done; next full word gives exactly one done.
    for (int i = 1; i <= 6; i++)
      step(0, 1, SHR, 8'h00, 0, 1, ones << (8 - i), CW'(i), 0);
    step(1, 1, SHR, 8'h00, 0, 1, 8'h00, 0, 0);
    for (int i = 1; i <= 8; i++)
      step(0, 1, SHR, 8'h00, 0, 1, ones << (8 - i), CW'(i % 8), i == 8);

    // Back-to-back word with no gap, then en=0 clears done.
    for (int i = 1; i <= 8; i++)
      step(0, 1, SHL, 8'h00, 0, 0, ones << i, CW'(i % 8), i == 8);
    step(0, 0, SHL, 8'h00, 1, 0, 8'h00, 0, 0);

    // CLEAR restarts the word count.
    step(0, 1, LOAD, 8'h3C, 0, 0, 8'h3C, 0, 0);
    step(0, 1, SHL,  8'h00, 1, 0, 8'h79, 1, 0);
    step(0, 1, CLR,  8'hFF, 1, 1, 8'h00, 0, 0);

    // Parity vectors.
    step(0, 1, LOAD, 8'h07, 0, 0, 8'h07, 0, 0);
    step(0, 1, SHL,  8'h00, 0, 0, 8'h0E, 1, 0);
    step(0, 1, LOAD, 8'h03, 0, 0, 8'h03, 0, 0);
    step(0, 1, HOLD, 8'h00, 0, 0, 8'h03, 0, 0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clock);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
